pio_thresh_bank: RTL and testbench
==================================

Name: pio_thresh_bank

Overview:
- Parametrised successor to the single-channel Avalon-MM threshold output port.
- Holds N_CH threshold channels of WIDTH bits each. Software writes shadow registers, then commits them atomically to the output port.
- Commit either applies all new values at once (snap) or ramps each channel by one count per STEP_DIV cycles (slew).
- Sits on the Nios Avalon-MM bus and drives the ultrasonic receive threshold comparators.

Parameters:
- N_CH, 4, number of threshold channels (1..8).
- WIDTH, 7, bits per channel (1..32).
- ADDR_W, 3, address width; N_CH+2 must be ≤ 2^ADDR_W.
- STEP_DIV, 16, clock cycles per slew step (≥1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero-extended
- out_port  out  N_CH*WIDTH  active thresholds; channel k at bits [k*WIDTH +: WIDTH]
- busy  out  1  high while a slew is in progress

Behaviour:
- Reset (asynchronous, reset_n=0):
  - shadow[], target[], active[] = 0; slew_en = 0; state = IDLE; div_cnt = 0.
  - out_port = 0; busy = 0.
- Register map (a write is chipselect & ~write_n):
  - Address 0..N_CH-1: SHADOW[k], read/write, bits [WIDTH-1:0]; upper writedata bits ignored. Writing shadow never changes out_port.
  - Address N_CH: CTRL. bit0 = COMMIT (write-1 pulse, reads 0). bit1 = SLEW_EN (read/write).
  - Address N_CH+1: STATUS, read-only. bit0 = busy.
  - Other addresses: read 0, writes ignored.
  - readdata is a combinational mux of address; it has no side effects.
- Commit, written at edge T:
  - target[] <= shadow[] as it stood before T.
  - The commit uses the SLEW_EN value in the same write.
- Snap mode (SLEW_EN=0 at commit): active[] <= shadow[] at edge T. out_port shows the new values from cycle T+1. state stays IDLE.
- Slew mode (SLEW_EN=1 at commit):
  - If active == target for every channel, state stays IDLE.
  - Otherwise state <= SLEW and div_cnt <= 0 at edge T.
- In SLEW:
  - div_cnt increments each cycle.
  - When div_cnt == STEP_DIV-1: div_cnt <= 0, and each channel with active ≠ target steps ±1 toward target. Channels step independently and may move in mixed directions.
  - The first step lands STEP_DIV cycles after T.
  - A channel never overshoots or wraps; arithmetic is unsigned, WIDTH bits.
  - When a step makes all channels equal to target, state <= IDLE on that same edge.
- busy = (state == SLEW), registered.
- Commit while in SLEW:
  - target[] is reloaded from shadow; div_cnt is not reset; the ramp continues toward the new target.
  - If that commit has SLEW_EN=0, active[] snaps to the new target and state goes to IDLE.
- Writing CTRL with SLEW_EN=0 and COMMIT=0 while in SLEW: active[] <= target[] at that edge; state <= IDLE.
- Writing CTRL with SLEW_EN=1 and COMMIT=0: updates the enable only; no transfer.
- Reset asserted mid-slew returns all state to reset values immediately.

Test Plan:
- Reset: assert reset_n=0 mid-activity → out_port=0, busy=0, all SHADOW/CTRL/STATUS read 0; after release, addresses 6 and 7 read 0.
- Snap commit (N_CH=4, WIDTH=7): write SHADOW0..3 = 10,20,30,127 → out_port unchanged. Write CTRL=0x1 → out_port = {127,30,20,10} one cycle after the write; busy stays 0.
- Slew (STEP_DIV=4): active ch0=0, write SHADOW0=5, CTRL=0x3 at T → busy=1 from T+1; ch0 = 1,2,3,4,5 at T+4, T+8, T+12, T+16, T+20; busy=0 from T+21; CTRL reads 0x2.
- Mixed directions: active {8,0}, shadow {5,2}, slew commit → ch0 steps down 8→5 and ch1 steps up 0→2 on the same edges; ch1 holds at 2 while ch0 finishes.
- Retarget mid-slew: during a 0→20 ramp at value 6, write SHADOW0=3 and CTRL=0x3 → ch0 ramps down 6→3 with no gap in step cadence. Then write CTRL=0x0 mid-ramp → ch0 = 3 on the next cycle, busy=0.
- Upper writedata bits: write 0xFFFFFF85 to SHADOW1 → reads back 0x05.

Source files
------------

// File: rtl/pio_thresh_bank.sv
// Bank of N_CH threshold outputs on an Avalon-MM slave. Software loads shadow registers,
// then a commit transfers them to the outputs either at once or as a one-count-per-step ramp.
module pio_thresh_bank #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 7,
  parameter int ADDR_W   = 3,
  parameter int STEP_DIV = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [N_CH*WIDTH-1:0]    out_port,
  output logic                     busy
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SLEW = 1'b1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(N_CH);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(N_CH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);

  logic [WIDTH-1:0] shadow_reg [N_CH];
  logic [WIDTH-1:0] shadow_next [N_CH];
  logic [WIDTH-1:0] target_reg [N_CH];
  logic [WIDTH-1:0] target_next [N_CH];
  logic [WIDTH-1:0] active_reg [N_CH];
  logic [WIDTH-1:0] active_next [N_CH];
  logic             slew_en_reg, slew_en_next;
  logic [0:0]       state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;

  logic             wr_en, ctrl_wr, commit, step_now;
  logic [WIDTH-1:0] tgt_eff [N_CH];
  logic [WIDTH-1:0] stepped [N_CH];
  logic [N_CH-1:0]  done_vec;
  logic [N_CH-1:0]  match_vec;
  logic             unused_wdata;

  assign wr_en    = chipselect & ~write_n;
  assign ctrl_wr  = wr_en && (address == CTRL_ADDR);
  assign commit   = ctrl_wr && writedata[0];
  assign step_now = (div_cnt_reg == DIV_LAST);
  assign busy     = (state_reg == SLEW);
  assign unused_wdata = ^writedata;

  // A commit landing mid-ramp makes this edge's step already head for the new target.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign tgt_eff[gi] = commit ? shadow_reg[gi] : target_reg[gi];
      assign stepped[gi] = (active_reg[gi] < tgt_eff[gi]) ? active_reg[gi] + WIDTH'(1) :
                           (active_reg[gi] > tgt_eff[gi]) ? active_reg[gi] - WIDTH'(1) :
                           active_reg[gi];
      assign done_vec[gi]  = (stepped[gi] == tgt_eff[gi]);
      assign match_vec[gi] = (active_reg[gi] == shadow_reg[gi]);
      assign out_port[gi*WIDTH +: WIDTH] = active_reg[gi];
    end
  endgenerate

  always_comb begin
    shadow_next  = shadow_reg;
    target_next  = target_reg;
    active_next  = active_reg;
    slew_en_next = slew_en_reg;
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;

    for (int k = 0; k < N_CH; k++) begin
      if (wr_en && (address == ADDR_W'(k))) shadow_next[k] = writedata[WIDTH-1:0];
    end

    if (state_reg == SLEW) begin
      if (step_now) begin
        div_cnt_next = '0;
        active_next  = stepped;
        if (&done_vec) state_next = IDLE;
      end else begin
        div_cnt_next = div_cnt_reg + DIV_W'(1);
      end
    end

    // Control writes take priority over the ramp in progress.
    if (ctrl_wr) begin
      slew_en_next = writedata[1];
      if (commit) begin
        target_next = shadow_reg;
        if (!writedata[1]) begin
          active_next = shadow_reg;
          state_next  = IDLE;
        end else if (state_reg == IDLE && !(&match_vec)) begin
          state_next   = SLEW;
          div_cnt_next = '0;
        end
      end else if (!writedata[1] && state_reg == SLEW) begin
        active_next = target_reg;
        state_next  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_CH; k++) begin
        shadow_reg[k] <= '0;
        target_reg[k] <= '0;
        active_reg[k] <= '0;
      end
      slew_en_reg <= 1'b0;
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
    end else begin
      shadow_reg  <= shadow_next;
      target_reg  <= target_next;
      active_reg  <= active_next;
      slew_en_reg <= slew_en_next;
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
    end
  end

  always_comb begin
    readdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (address == ADDR_W'(k)) readdata = 32'(shadow_reg[k]);
    end
    if (address == CTRL_ADDR) readdata = {30'd0, slew_en_reg, 1'b0};
    else if (address == STAT_ADDR) readdata = {31'd0, busy};
  end

endmodule

// File: tb/tb_pio_thresh_bank.sv
// Directed bench for pio_thresh_bank: expectations queued with each bus step, checked after the edge.
module tb_pio_thresh_bank;
  localparam int N_CH = 4;
  localparam int WIDTH = 7;
  localparam int ADDR_W = 3;
  localparam int STEP_DIV = 4;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [ADDR_W-1:0]     address = '0;
  logic                  chipselect = 1'b0;
  logic                  write_n = 1'b1;
  logic [31:0]           writedata = '0;
  logic [31:0]           readdata;
  logic [N_CH*WIDTH-1:0] out_port;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          sel;   // 0..N_CH-1 channel, 8 busy, 9 readdata, 10 whole out_port
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pio_thresh_bank #(
    .N_CH(N_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .busy(busy)
  );

  function automatic logic [31:0] observe(input int sel);
    if (sel < N_CH) return 32'(out_port[sel*WIDTH +: WIDTH]);
    if (sel == 8) return {31'd0, busy};
    if (sel == 9) return readdata;
    return 32'(out_port);
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
      end
      $display("check %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc(input bit we, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = we; write_n = ~we;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    push(tag, 9, exp);
    @(negedge clk);
    drain();
    chipselect = 1'b0;
  endtask

  initial begin
    int v0, v1;
    // Reset
    repeat (3) @(posedge clk); #1;
    push("rst_out", 10, 0); push("rst_busy", 8, 0); drain();
    @(negedge clk); reset_n = 1'b1;

    // Slew 0 -> 5 on ch0
    cyc(1, 0, 5); push("shadow_no_out", 10, 0); drain();
    cyc(1, 4, 3); push("slew_busy_T", 8, 1); push("slew_ch0_T", 0, 0); drain();
    for (int n = 1; n <= 21; n++) begin
      cyc(0, 0, 0);
      v0 = (n / STEP_DIV > 5) ? 5 : n / STEP_DIV;
      push($sformatf("slew_ch0_n%0d", n), 0, v0);
      push($sformatf("slew_busy_n%0d", n), 8, (n < 20) ? 1 : 0);
      drain();
    end
    rd(4, 2, "ctrl_slew_en");
    rd(5, 0, "status_idle");

    // Mixed directions: {8,0} -> {5,2}
    cyc(1, 0, 8); cyc(1, 4, 1);
    push("mix_snap_ch0", 0, 8); push("mix_snap_ch1", 1, 0); push("mix_snap_busy", 8, 0); drain();
    cyc(1, 0, 5); cyc(1, 1, 2); cyc(1, 4, 3);
    push("mix_busy_T", 8, 1); drain();
    for (int n = 1; n <= 13; n++) begin
      cyc(0, 0, 0);
      v0 = 8 - ((n / STEP_DIV > 3) ? 3 : n / STEP_DIV);
      v1 = (n / STEP_DIV > 2) ? 2 : n / STEP_DIV;
      push($sformatf("mix_ch0_n%0d", n), 0, v0);
      push($sformatf("mix_ch1_n%0d", n), 1, v1);
      push($sformatf("mix_busy_n%0d", n), 8, (n < 12) ? 1 : 0);
      drain();
    end

    // Retarget mid-ramp, then abort
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 4, 1);
    push("rt_snap_zero", 10, 0); drain();
    cyc(1, 0, 20); cyc(1, 4, 3);
    for (int n = 1; n <= 24; n++) begin
      cyc(0, 0, 0);
      push($sformatf("rt_up_ch0_n%0d", n), 0, n / STEP_DIV);
      push($sformatf("rt_up_busy_n%0d", n), 8, 1);
      drain();
    end
    cyc(1, 0, 3);  push("rt_n25_ch0", 0, 6); push("rt_n25_busy", 8, 1); drain();
    cyc(1, 4, 3);  push("rt_n26_ch0", 0, 6); push("rt_n26_busy", 8, 1); drain();
    cyc(0, 0, 0);  push("rt_n27_ch0", 0, 6); drain();
    cyc(0, 0, 0);  push("rt_n28_ch0", 0, 5); push("rt_n28_busy", 8, 1); drain();
    cyc(0, 0, 0);  push("rt_n29_ch0", 0, 5); drain();
    cyc(1, 4, 0);  push("abort_ch0", 0, 3); push("abort_busy", 8, 0); drain();
    cyc(0, 0, 0);  push("abort_hold_ch0", 0, 3); push("abort_hold_busy", 8, 0); drain();
    rd(4, 0, "abort_ctrl");

    // Reset in the middle of a ramp
    cyc(1, 0, 100); cyc(1, 4, 3);
    repeat (6) cyc(0, 0, 0);
    push("pre_rst_ch0", 0, 4); push("pre_rst_busy", 8, 1); drain();
    @(negedge clk); reset_n = 1'b0; #1;
    push("midrst_out", 10, 0); push("midrst_busy", 8, 0); drain();
    for (int a = 0; a < N_CH + 2; a++) rd(ADDR_W'(a), 0, $sformatf("midrst_rd%0d", a));
    @(negedge clk); reset_n = 1'b1;
    rd(6, 0, "rd_addr6");
    rd(7, 0, "rd_addr7");

    // Snap commit
    cyc(1, 0, 10);  push("snap_w0_out", 10, 0); drain();
    cyc(1, 1, 20);  push("snap_w1_out", 10, 0); drain();
    cyc(1, 2, 30);  push("snap_w2_out", 10, 0); drain();
    cyc(1, 3, 127); push("snap_w3_out", 10, 0); drain();
    cyc(1, 4, 1);
    push("snap_out", 10, (127 << 21) | (30 << 14) | (20 << 7) | 10); push("snap_busy", 8, 0); drain();
    cyc(0, 0, 0);
    push("snap_hold", 10, (127 << 21) | (30 << 14) | (20 << 7) | 10); push("snap_hold_busy", 8, 0); drain();
    rd(0, 10, "snap_rd_shadow0");

    // Upper writedata bits ignored
    cyc(1, 1, 32'hFFFF_FF85);
    push("upper_out_unchanged", 1, 20); drain();
    rd(1, 5, "upper_rd_shadow1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
